// File: rtl/led_mode_scheduler.sv
// Animation mode sequencer: advances mode on a debounced button press or dwell expiry,
// and applies each change only at an animation frame boundary (or after a timeout).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | scheduler disabled, mode held, outputs quiet
// RUN     | dwell timer running, watching for a press or dwell expiry
// PENDING | change requested, waiting for frame_done or timeout
// SWITCH  | one cycle: new mode applied, animation restart pulsed
module led_mode_scheduler #(
    parameter int START_MODE      = 2,
    parameter int DWELL_CYCLES    = 2500000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FRAME_TIMEOUT   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       auto_en,
    input  logic       btn,
    input  logic       frame_done,
    output logic [1:0] mode,
    output logic       anim_rst,
    output logic       switching
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int TMO_W   = $clog2(FRAME_TIMEOUT);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(FRAME_TIMEOUT - 1);
    localparam logic [1:0]         MODE_INIT  = 2'(START_MODE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2,
        SWITCH  = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         next_mode;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               btn_meta;
    logic               btn_sync;
    logic               db_level;
    logic [DB_W-1:0]    db_cnt;
    logic               press;

    logic               dwell_hit;
    logic               tmo_hit;

    assign dwell_hit = auto_en && (dwell_cnt == DWELL_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // Debounced level only moves after the synchronized input disagrees for a full window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            press    <= 1'b0;
            if (btn_sync != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= btn_sync;
                    db_cnt   <= '0;
                    press    <= btn_sync;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mode      <= MODE_INIT;
            next_mode <= MODE_INIT;
            anim_rst  <= 1'b0;
            switching <= 1'b0;
            dwell_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            anim_rst <= 1'b0;
            case (state)
                IDLE: begin
                    switching <= 1'b0;
                    dwell_cnt <= '0;
                    tmo_cnt   <= '0;
                    if (enable) begin
                        // Entering from IDLE just restarts the animation on the current mode.
                        state     <= SWITCH;
                        next_mode <= mode;
                        anim_rst  <= 1'b1;
                        switching <= 1'b1;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        switching <= 1'b0;
                        dwell_cnt <= '0;
                    end else if (press || dwell_hit) begin
                        state     <= PENDING;
                        next_mode <= mode + 2'd1;
                        dwell_cnt <= '0;
                        tmo_cnt   <= '0;
                        switching <= 1'b1;
                    end else if (auto_en) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                PENDING: begin
                    if (!enable) begin
                        state     <= IDLE;
                        switching <= 1'b0;
                        dwell_cnt <= '0;
                        tmo_cnt   <= '0;
                    end else if (frame_done || tmo_hit) begin
                        state     <= SWITCH;
                        mode      <= next_mode;
                        anim_rst  <= 1'b1;
                        switching <= 1'b1;
                        dwell_cnt <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                SWITCH: begin
                    switching <= 1'b0;
                    dwell_cnt <= '0;
                    tmo_cnt   <= '0;
                    state     <= enable ? RUN : IDLE;
                end

                default: begin
                    state     <= IDLE;
                    switching <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with small timing parameters and
// hand-computed pulse times and mode sequences.
module tb_led_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       auto_en = 1'b0;
    logic       btn = 1'b0;
    logic       frame_done = 1'b0;
    logic [1:0] mode;
    logic       anim_rst;
    logic       switching;

    int checks = 0;
    int errors = 0;

    int         pulses;
    int         sw_total;
    int         sw_len;
    int         stray = 0;
    int         pulse_time [8];
    logic [1:0] pulse_mode [8];

    always #5 clk = ~clk;

    led_mode_scheduler #(
        .START_MODE     (2),
        .DWELL_CYCLES   (8),
        .DEBOUNCE_CYCLES(4),
        .FRAME_TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .auto_en   (auto_en),
        .btn       (btn),
        .frame_done(frame_done),
        .mode      (mode),
        .anim_rst  (anim_rst),
        .switching (switching)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Steps up to max_cyc negedges (stopping once `want` anim_rst pulses are seen),
    // driving btn from pat (bit c at step c) and strobing frame_done when switching
    // has been high for fd_age samples (0 = never).
    task automatic watch(input int max_cyc, input int want, input int fd_age, input logic [63:0] pat);
        int         age;
        logic [1:0] prev;
        age      = 0;
        pulses   = 0;
        sw_total = 0;
        sw_len   = -1;
        prev     = mode;
        for (int c = 0; c < max_cyc && pulses < want; c++) begin
            @(negedge clk);
            if (mode !== prev && anim_rst !== 1'b1) stray++;
            prev = mode;
            if (switching === 1'b1) begin
                age++;
                sw_total++;
            end else begin
                age = 0;
            end
            if (anim_rst === 1'b1) begin
                if (pulses < 8) begin
                    pulse_time[pulses] = c;
                    pulse_mode[pulses] = mode;
                end
                sw_len = age - 1;
                pulses++;
            end
            frame_done = (fd_age != 0) && (age == fd_age);
            btn        = (c < 64) ? pat[c] : 1'b0;
        end
        frame_done = 1'b0;
    endtask

    initial begin
        // 1: reset, then enable restarts the animation on START_MODE
        repeat (3) @(negedge clk);
        check_val("rst_mode", mode, 2);
        check_val("rst_anim", anim_rst, 0);
        check_val("rst_sw", switching, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_anim", anim_rst, 0);
        check_val("idle_sw", switching, 0);
        enable = 1'b1;
        watch(20, 99, 0, 64'h0);
        check_val("t1_pulses", pulses, 1);
        check_val("t1_time", pulse_time[0], 0);
        check_val("t1_mode", pulse_mode[0], 2);
        check_val("t1_sw_total", sw_total, 1);
        check_val("t1_mode_end", mode, 2);

        // 2: auto advance with frame_done three samples into switching
        auto_en = 1'b1;
        watch(80, 4, 3, 64'h0);
        auto_en = 1'b0;
        check_val("t2_pulses", pulses, 4);
        check_val("t2_time0", pulse_time[0], 10);
        check_val("t2_time1", pulse_time[1], 22);
        check_val("t2_time2", pulse_time[2], 34);
        check_val("t2_time3", pulse_time[3], 46);
        check_val("t2_mode0", pulse_mode[0], 3);
        check_val("t2_mode1", pulse_mode[1], 0);
        check_val("t2_mode2", pulse_mode[2], 1);
        check_val("t2_mode3", pulse_mode[3], 2);
        check_val("t2_sw_len", sw_len, 3);

        // 3: bouncing button then held; one advance, release ignored
        watch(50, 99, 1, 64'h0000_0000_003F_FFFD);
        check_val("t3_pulses", pulses, 1);
        check_val("t3_time", pulse_time[0], 10);
        check_val("t3_mode", mode, 3);

        // 4: dwell request with no frame_done -> timeout
        auto_en = 1'b1;
        watch(60, 1, 0, 64'h0);
        auto_en = 1'b0;
        check_val("t4_pulses", pulses, 1);
        check_val("t4_time", pulse_time[0], 23);
        check_val("t4_sw_len", sw_len, 16);
        check_val("t4_mode", mode, 0);

        // 5a: second press lands during PENDING and is dropped
        watch(60, 99, 0, 64'h0000_0000_7FFF_C07F);
        check_val("t5a_pulses", pulses, 1);
        check_val("t5a_time", pulse_time[0], 23);
        check_val("t5a_sw_len", sw_len, 16);
        check_val("t5a_mode", mode, 1);

        // 5b: press and dwell expiry in the same cycle -> one advance
        auto_en = 1'b1;
        watch(30, 1, 1, 64'h0000_0000_0000_03FF);
        auto_en = 1'b0;
        check_val("t5b_pulses", pulses, 1);
        check_val("t5b_time", pulse_time[0], 8);
        check_val("t5b_mode", mode, 2);
        watch(30, 99, 1, 64'h0);
        check_val("t5b_no_extra", pulses, 0);
        check_val("t5b_mode_end", mode, 2);

        // 6: enable drop while PENDING, then reset mid-RUN
        auto_en = 1'b1;
        repeat (9) @(negedge clk);
        check_val("t6_pending_sw", switching, 1);
        enable = 1'b0;
        @(negedge clk);
        check_val("t6_idle_sw", switching, 0);
        check_val("t6_idle_anim", anim_rst, 0);
        check_val("t6_idle_mode", mode, 2);
        auto_en = 1'b0;
        watch(10, 99, 0, 64'h0);
        check_val("t6_idle_pulses", pulses, 0);
        check_val("t6_idle_mode_end", mode, 2);
        enable = 1'b1;
        watch(5, 99, 1, 64'h0);
        check_val("t6_reen_pulses", pulses, 1);
        check_val("t6_reen_time", pulse_time[0], 0);
        check_val("t6_reen_mode", pulse_mode[0], 2);
        auto_en = 1'b1;
        watch(60, 2, 1, 64'h0);
        auto_en = 1'b0;
        check_val("t6_adv_pulses", pulses, 2);
        check_val("t6_adv_time1", pulse_time[1], 18);
        check_val("t6_adv_mode", mode, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("t6_rst_mode", mode, 2);
        check_val("t6_rst_anim", anim_rst, 0);
        check_val("t6_rst_sw", switching, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        watch(6, 99, 0, 64'h0);
        check_val("t6_post_pulses", pulses, 0);
        check_val("t6_post_mode", mode, 2);

        check_val("stray_mode_changes", stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_mode_scheduler.md
Name: led_mode_scheduler

Overview:
- Sequences the animation mode driven into the LED animation top (`mode[1:0]` -> `led_out[7:0]` path).
- Mode advances on a debounced user button, or automatically after a programmable dwell time.
- A change never takes effect mid-frame: the block waits for the animation's frame-boundary strobe (bounded by a timeout), then pulses an animation restart.
- Sits between board inputs and the animation top, replacing direct drive of `mode`.

Parameters:
- START_MODE, 2, mode loaded at reset (0..3)
- DWELL_CYCLES, 2500000, auto-advance period in clocks while running with `auto_en`=1 (>=2)
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a button level change (>=2)
- FRAME_TIMEOUT, 1000000, max clocks spent waiting for `frame_done` before forcing the switch (>=2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset, sampled on rising `clk`
- enable  input  1  scheduler run enable
- auto_en  input  1  enables dwell-timer auto advance
- btn  input  1  raw asynchronous push button, active high
- frame_done  input  1  one-cycle strobe from animation at end of frame
- mode  output  2  animation mode to animation top
- anim_rst  output  1  one-cycle restart pulse to animation
- switching  output  1  high while a mode change is pending or being applied

Behaviour:
- Reset (rst=0 at rising `clk`):
  - Outputs: mode=START_MODE, anim_rst=0, switching=0.
  - State=IDLE; dwell, debounce and timeout counters = 0; debounced button level = 0; synchronizer flops = 0.
  - Reset mid-operation (any state) aborts any pending change; `mode` returns to START_MODE.
- Button path:
  - `btn` passes through a 2-flop synchronizer.
  - Debounced level toggles only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A 0->1 transition of the debounced level produces a one-cycle internal `press`.
  - Release produces nothing.
  - Held button = one press only.
- States: IDLE, RUN, PENDING, SWITCH.
- IDLE:
  - Outputs: mode held, anim_rst=0, switching=0.
  - enable=1 -> SWITCH. `mode` is unchanged, so this only restarts the animation.
- RUN:
  - Dwell counter increments each cycle while auto_en=1; it is held (not cleared) while auto_en=0.
  - A request fires on `press`, or when auto_en=1 and counter==DWELL_CYCLES-1.
  - On a request: `next_mode` = mode+1 mod 4 (3 wraps to 0), dwell counter cleared, go to PENDING.
  - Button and dwell expiry in the same cycle = one request, one advance.
- PENDING:
  - switching=1.
  - Timeout counter increments from 0.
  - `frame_done` is sampled only in this state. A strobe in the same cycle as the RUN request is ignored.
  - Exit to SWITCH on frame_done=1, or when timeout counter==FRAME_TIMEOUT-1, whichever comes first.
  - `press` during PENDING is discarded (no queueing).
- SWITCH (exactly one cycle):
  - anim_rst=1, switching=1.
  - `mode` updated to `next_mode` at the same clock edge that enters SWITCH, so the new mode and anim_rst are visible together.
  - Dwell and timeout counters cleared.
  - Next state: RUN.
  - From IDLE entry, `next_mode` = current mode.
- enable=0 sampled in RUN, PENDING or SWITCH:
  - Next state IDLE; pending change dropped; mode held; dwell counter cleared.
  - enable=0 overrides a simultaneous request or frame_done.
- Latencies:
  - Auto advance: with no stalls, anim_rst rises DWELL_CYCLES + (PENDING cycles) + 1 clocks after entering RUN.
  - Button: first anim_rst no earlier than 2 + DEBOUNCE_CYCLES + 2 clocks after `btn` rises.
- Width rules:
  - `mode` arithmetic is modulo 4.
  - Counters sized $clog2 of their parameter; no counter exceeds its terminal value.

Test Plan (DWELL_CYCLES=8, DEBOUNCE_CYCLES=4, FRAME_TIMEOUT=16, START_MODE=2):
1. Reset then enable=1, auto_en=0, no btn -> mode=2 throughout; single anim_rst pulse 1 cycle after enable sampled; switching=1 only in that cycle.
2. auto_en=1, frame_done strobed 3 cycles after switching rises -> mode sequence 2,3,0,1,2; anim_rst coincides with each mode change; wrap 3->0 correct.
3. btn bounces 1,0,1 at 1-cycle intervals, then held high for 20 cycles, frame_done prompt -> exactly one advance (2->3); no advance on release.
4. Request with frame_done never asserted -> switching high for exactly 16 cycles, then anim_rst pulse, mode advances.
5. Press during PENDING plus simultaneous press/dwell expiry -> exactly one advance per request; extra press ignored.
6. enable=0 while PENDING, then rst=0 mid-RUN at mode=0 -> IDLE with mode unchanged and no anim_rst; after reset mode=2, anim_rst=0, switching=0.
